// File: rtl/axi_lite_param_regbank.sv
// axi_lite_param_regbank: AXI4-Lite slave with NUM_CFG read/write config registers
// followed by NUM_STS read-only status words in a flat 32-bit word map.
//
// Ports:
//   S_AXI_CLK, S_AXI_ARESETN   clock and asynchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*     AXI4-Lite slave channels
//   cfg_o                      config register n on bits [32n+31:32n]
//   sts_i                      status word m, sampled at the read-address handshake
//   clr_i                      clr_i[n] clears the AUTOCLR_MASK bits of config register n
//   wr_pulse_o                 one-cycle strobe per config register on an AXI write
//
// Build option: define AXI_LITE_REGBANK_SLVERR_EN to answer status/out-of-range writes and
// out-of-range reads with SLVERR; otherwise BRESP/RRESP are always OKAY.
module axi_lite_param_regbank #(
    parameter int unsigned NUM_CFG      = 6,
    parameter int unsigned NUM_STS      = 2,
    parameter int unsigned ADDR_BITS    = 8,
    parameter logic [31:0] AUTOCLR_MASK = 32'h0
) (
    input  logic                                    S_AXI_CLK,
    input  logic                                    S_AXI_ARESETN,
    input  logic [31:0]                             S_AXI_AWADDR,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [31:0]                             S_AXI_WDATA,
    input  logic [3:0]                              S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [31:0]                             S_AXI_ARADDR,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [31:0]                             S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    output logic [NUM_CFG*32-1:0]                   cfg_o,
    input  logic [(NUM_STS == 0 ? 1 : NUM_STS)*32-1:0] sts_i,
    input  logic [NUM_CFG-1:0]                      clr_i,
    output logic [NUM_CFG-1:0]                      wr_pulse_o
);

`ifdef AXI_LITE_REGBANK_SLVERR_EN
    localparam bit SlvErrEn = 1'b1;
`else
    localparam bit SlvErrEn = 1'b0;
`endif

    localparam int unsigned NumWords = NUM_CFG + NUM_STS;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [ADDR_BITS-1:0] awaddr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic [1:0]           bresp_q;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;

    // Effective write transaction at the edge entering W_RESP: each field comes either
    // from the bus (handshake this cycle) or from the latch (earlier handshake).
    logic                 wr_commit;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic [31:0]          wr_lane_mask;
    int unsigned          wr_idx;
    int unsigned          rd_idx;

    logic unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_AWADDR[31:ADDR_BITS],
                           S_AXI_ARADDR[1:0], S_AXI_ARADDR[31:ADDR_BITS]};

    always_comb begin
        w_state_d     = w_state_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        wr_commit     = 1'b0;
        wr_addr       = awaddr_q;
        wr_data       = wdata_q;
        wr_strb       = wstrb_q;
        unique case (w_state_q)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                    wr_addr   = S_AXI_AWADDR[ADDR_BITS-1:0];
                    wr_data   = S_AXI_WDATA;
                    wr_strb   = S_AXI_WSTRB;
                end else if (S_AXI_AWVALID) begin
                    w_state_d = W_WAIT_DATA;
                end else if (S_AXI_WVALID) begin
                    w_state_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                    wr_data   = S_AXI_WDATA;
                    wr_strb   = S_AXI_WSTRB;
                end
            end
            W_WAIT_ADDR: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                    wr_addr   = S_AXI_AWADDR[ADDR_BITS-1:0];
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign wr_idx       = 32'(wr_addr[ADDR_BITS-1:2]);
    assign rd_idx       = 32'(S_AXI_ARADDR[ADDR_BITS-1:2]);
    assign wr_lane_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

    always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            if (S_AXI_AWVALID && S_AXI_AWREADY) awaddr_q <= S_AXI_AWADDR[ADDR_BITS-1:0];
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) bresp_q <= (SlvErrEn && (wr_idx >= NUM_CFG)) ? 2'b10 : 2'b00;
        end
    end

    assign S_AXI_BRESP = bresp_q;

    // Read mux as an OR chain; indices with no matching word fall through as zero.
    logic [31:0] rd_acc [NumWords+1];
    assign rd_acc[0] = '0;

    for (genvar n = 0; n < NUM_CFG; n++) begin : g_cfg
        logic [31:0] reg_q, reg_d;
        logic        hit, pulse_q;

        assign hit = wr_commit && (wr_idx == n);

        // Hardware clear first, then written lanes override, so masked bits in
        // enabled lanes take the written value and the rest clear.
        always_comb begin
            reg_d = reg_q;
            if (clr_i[n]) reg_d = reg_d & ~AUTOCLR_MASK;
            if (hit) reg_d = (reg_d & ~wr_lane_mask) | (wr_data & wr_lane_mask);
        end

        always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                reg_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                reg_q   <= reg_d;
                pulse_q <= hit;
            end
        end

        assign cfg_o[32*n +: 32] = reg_q;
        assign wr_pulse_o[n]     = pulse_q;
        assign rd_acc[n+1]       = rd_acc[n] | ((rd_idx == n) ? reg_q : 32'h0);
    end

    for (genvar m = 0; m < NUM_STS; m++) begin : g_sts
        assign rd_acc[NUM_CFG+m+1] = rd_acc[NUM_CFG+m] |
                                     ((rd_idx == NUM_CFG + m) ? sts_i[32*m +: 32] : 32'h0);
    end

    always_comb begin
        r_state_d     = r_state_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_state_d = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Sampled with the pre-edge register values, so a read coinciding with a
    // write update returns the old contents.
    always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rdata_q <= rd_acc[NumWords];
                rresp_q <= (SlvErrEn && (rd_idx >= NumWords)) ? 2'b10 : 2'b00;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

endmodule

// File: doc/axi_lite_param_regbank.md
AXI_LITE_PARAM_REGBANK -- requirements
Module: axi_lite_param_regbank

Interface
REQ-001 Parameter NUM_CFG, default 6, number of 32-bit read/write config registers (1..32).
REQ-002 Parameter NUM_STS, default 2, number of 32-bit read-only status registers (0..32).
REQ-003 Parameter ADDR_BITS, default 8, decoded address bits; SHALL satisfy 4*(NUM_CFG+NUM_STS) <= 2**ADDR_BITS.
REQ-004 Parameter AUTOCLR_MASK, default 32'h0, bits clearable by hardware in every config register.
REQ-005 S_AXI_CLK  in  1  single clock; all logic on rising edge.
REQ-006 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 cfg_o  out  NUM_CFG*32  config register n on bits [32n+31:32n].
REQ-008 sts_i  in  NUM_STS*32  status word m, sampled at read-address handshake.
REQ-009 clr_i  in  NUM_CFG  clr_i[n] clears AUTOCLR_MASK bits of config register n.
REQ-010 wr_pulse_o  out  NUM_CFG  one-cycle strobe per config register on AXI write.
REQ-011 AXI4-Lite slave: AWADDR/ARADDR 32, WDATA/RDATA 32, WSTRB 4, BRESP/RRESP 2, AWVALID/AWREADY, WVALID/WREADY, BVALID/BREADY, ARVALID/ARREADY, RVALID/RREADY, all 1, standard directions.

Function
REQ-012 Address map: config n at byte 4n; status m at byte 4(NUM_CFG+m); ADDR bits [1:0] and bits above ADDR_BITS ignored.
REQ-013 Write FSM states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP; AWREADY=1 in W_IDLE/W_WAIT_ADDR; WREADY=1 in W_IDLE/W_WAIT_DATA; BVALID=1 only in W_RESP.
REQ-014 W_IDLE: AW-only handshake -> W_WAIT_DATA; W-only -> W_WAIT_ADDR; both same cycle -> W_RESP; address/data/strobe latched at their handshake.
REQ-015 W_WAIT_DATA on W handshake, W_WAIT_ADDR on AW handshake -> W_RESP; W_RESP -> W_IDLE when BREADY=1, else hold BVALID/BRESP stable.
REQ-016 Register update on the edge entering W_RESP; byte lane k written only when WSTRB[k]=1; new value visible on cfg_o and BVALID=1 the next cycle.
REQ-017 wr_pulse_o[n] high exactly in the first W_RESP cycle of a write decoding to config n, regardless of WSTRB.
REQ-018 Writes to status or out-of-range addresses SHALL not modify any register nor pulse wr_pulse_o.
REQ-019 clr_i[n]=1 clears AUTOCLR_MASK bits of register n next edge; on simultaneous AXI update, bits in enabled byte lanes take the written value, other masked bits clear.
REQ-020 Read FSM states R_IDLE (ARREADY=1), R_DATA (RVALID=1); AR handshake latches RDATA and -> R_DATA; R_DATA -> R_IDLE on RREADY; RDATA/RRESP stable while RVALID.
REQ-021 Read of out-of-range address returns RDATA=0; read and write channels operate concurrently; a read of a register being written returns the pre-update value if the AR handshake precedes or coincides with the update edge.

Reset
REQ-022 While S_AXI_ARESETN=0: FSMs in W_IDLE/R_IDLE, cfg_o=0, wr_pulse_o=0, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=2'b00, latched address/data cleared.
REQ-023 Reset asserted mid-transaction SHALL abort it with no register update; deassertion resumes in idle states on the next edge.

Configuration
REQ-024 Macro AXI_LITE_REGBANK_SLVERR_EN defined: out-of-range or status-register writes return BRESP=2'b10 and out-of-range reads return RRESP=2'b10; undefined: BRESP/RRESP always 2'b00.

Verification
REQ-025 AW 0x04 and W 0xDEADBEEF strobe 4'hF same cycle -> BVALID next cycle, cfg_o reg1=0xDEADBEEF, wr_pulse_o=6'b000010 one cycle.
REQ-026 W 0x11223344 strobe 4'b0101 three cycles before AW 0x00 (reg0 was 0xFFFFFFFF) -> reg0=0xFF22FF44, BRESP=00.
REQ-027 AUTOCLR_MASK=0x1, reg2=0x00000003, clr_i[2]=1 -> reg2=0x00000002 next cycle; same-cycle write 0x5 strobe 4'h1 -> reg2=0x00000005.
REQ-028 NUM_CFG=6, NUM_STS=2, sts_i word1=0xCAFE0001, AR 0x1C with RREADY low 3 cycles -> RVALID held, RDATA=0xCAFE0001 stable, RRESP=00.
REQ-029 AW 0x40, W 0x12345678 and AR 0x40 -> no register change, RDATA=0; BRESP/RRESP=2'b10 with macro, 2'b00 without.
REQ-030 Assert reset in W_WAIT_DATA after AW 0x08 -> AWREADY=1, BVALID=0, reg2 unchanged (0) after release.
